// File: rtl/m6809_pkg.sv
// m6809 fetch unit shared types and constants.
// Imported by the fetch top and its prefetch FIFO.
package m6809_pkg;

  localparam int          ADDR_W_DEF      = 16;
  localparam logic [15:0] VECTOR_ADDR_DEF = 16'hFFFE;

  typedef enum logic [1:0] {
    VEC_HI,
    VEC_LO,
    FETCH,
    STALL
  } fetch_state_t;

endpackage

// File: rtl/m6809_fetch_fifo.sv
// Prefetch FIFO of {pc, byte} entries.
// Clear has priority over push and pop.
module fetch_fifo
  import m6809_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 24,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign valid   = count != '0;
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + PW'(1);
      end
      if (do_pop) rp <= rp + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/m6809_fetch.sv
// m6809 boot fetch: loads the reset vector, then streams
// opcode bytes into a prefetch FIFO for the decoder.
module m6809_fetch
  import m6809_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] VECTOR_ADDR = VECTOR_ADDR_DEF,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_din,
  output logic              op_valid,
  output logic [7:0]        op_data,
  output logic [ADDR_W-1:0] op_pc,
  input  logic              op_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              boot_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rd_a;
  logic [WW-1:0]     wcnt;
  logic [CW-1:0]     count;
  logic              full;
  logic              done;
  logic              do_flush;
  logic              issue;
  logic              push;

  assign full     = count == CW'(FIFO_DEPTH);
  assign done     = mem_sel && (wcnt == WW'(WAIT_STATES));
  assign do_flush = flush && boot_done;

  always_comb begin
    state_n = state;
    push    = 1'b0;
    issue   = 1'b0;
    rd_a    = pc;
    unique case (state)
      VEC_HI: begin
        rd_a  = VECTOR_ADDR;
        issue = !mem_sel;
        if (done) state_n = VEC_LO;
      end
      VEC_LO: begin
        rd_a  = VECTOR_ADDR + ADDR_W'(1);
        issue = !mem_sel;
        if (done) state_n = FETCH;
      end
      FETCH: begin
        issue = !mem_sel && !full;
        push  = done;
        if (!mem_sel && full) state_n = STALL;
      end
      STALL: begin
        if (!full) state_n = FETCH;
      end
      default: state_n = VEC_HI;
    endcase
    // a redirect kills the in-flight read and any push it would make
    if (do_flush) begin
      state_n = FETCH;
      push    = 1'b0;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= VEC_HI;
      mem_sel   <= 1'b0;
      mem_a     <= VECTOR_ADDR;
      pc        <= '0;
      wcnt      <= '0;
      boot_done <= 1'b0;
    end else begin
      state <= state_n;
      if (do_flush) begin
        mem_sel <= 1'b0;
        mem_a   <= flush_pc;
        wcnt    <= '0;
        pc      <= flush_pc;
      end else if (issue) begin
        mem_sel <= 1'b1;
        mem_a   <= rd_a;
        wcnt    <= '0;
      end else if (done) begin
        mem_sel <= 1'b0;
        wcnt    <= '0;
        case (state)
          VEC_HI: pc[15:8] <= mem_din;
          VEC_LO: begin
            pc[7:0]   <= mem_din;
            boot_done <= 1'b1;
          end
          FETCH:   pc <= pc + ADDR_W'(1);
          default: ;
        endcase
      end else if (mem_sel) begin
        wcnt <= wcnt + WW'(1);
      end else if (state_n == STALL) begin
        mem_a <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ADDR_W + 8),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (do_flush),
    .push  (push),
    .din   ({pc, mem_din}),
    .pop   (op_ready && !do_flush),
    .dout  ({op_pc, op_data}),
    .valid (op_valid),
    .count (count)
  );

endmodule
